fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Program-counter and fetch-sequencing stage that sits directly upstream of the byte-addressed instruction memory.
- Drives the memory's PC input and aligns the memory's registered instruction output with the PC that produced it.
- Presents a valid fetched instruction to decode, with stall hold, branch/jump redirect, flush and out-of-range fault detection.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- MEM_BYTES, 128, instruction memory size in bytes; used only for range checking.

Ports:
- clk  input  1  rising-edge clock; the instruction memory shares this clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  decode cannot accept; hold the current fetch output.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC, byte address.
- mem_instruction  input  32  registered memory output; holds instmem[PC sampled at the previous edge].
- mem_pc  output  32  PC driven to the instruction memory; equals the internal PC register.
- if_pc  output  32  PC of the presented instruction.
- if_instr  output  32  presented instruction.
- if_valid  output  1  presented instruction is valid.
- misalign_err  output  1  one-cycle pulse: redirect target had nonzero [1:0].
- fetch_fault  output  1  sticky: a fetch addressed beyond MEM_BYTES.
- instr_count  output  32  count of instructions accepted by decode.

Behaviour:
- Reset (async, rst_n=0). Immediately set:
  - PC=RESET_PC, if_pc=RESET_PC, if_valid=0, hold_instr=0, state=RUN.
  - misalign_err=0, fetch_fault=0, instr_count=0.
  - Reset mid-stall or mid-redirect discards all pending state.
- States:
  - RUN: if_instr = mem_instruction (combinational pass-through).
  - STALL: if_instr = hold_instr.
- Latency: one cycle. The instruction for PC p appears the cycle after the edge at which mem_pc=p is sampled.
- Each rising edge, evaluated in priority order:
  1. redirect_valid=1 (overrides stall):
     - PC <= {redirect_target[31:2],2'b00}; if_valid <= 0; state <= RUN.
     - misalign_err <= (redirect_target[1:0]!=0); it is 0 on every other edge.
  2. stall=1 in RUN:
     - hold_instr <= mem_instruction; state <= STALL.
     - PC, if_pc and if_valid hold.
  3. stall=1 in STALL: everything holds; hold_instr is not recaptured.
  4. Otherwise (accept/advance):
     - if_pc <= PC; PC <= PC+4 (32-bit wrap); state <= RUN.
     - if_valid <= 1 unless PC+3 >= MEM_BYTES. In that case if_valid <= 0 and fetch_fault <= 1.
     - fetch_fault clears only on reset or on a redirect to an in-range target.
- instr_count increments by 1 (wrapping) on every edge where if_valid=1, stall=0 and redirect_valid=0.
- Stall release:
  - The first cycle after stall drops still shows hold_instr.
  - The next edge advances normally. mem_instruction is then instmem[held PC], so no instruction is lost or duplicated.
- Redirect flush: the instruction already in flight (from the old PC) is presented with if_valid=0. The first valid instruction from the target appears two edges after the redirect edge.
- Stall with if_valid=0 holds an invalid slot; it never turns valid.

Test Plan:
- Setup: memory words at bytes 0,4,8,12,16 = 1,2,3,4,5.
- Reset release, no stall: if_valid=0 in the first cycle. Then (if_pc,if_instr) = (0,1),(4,2),(8,3),(12,4),(16,5) on consecutive cycles; instr_count=5 after the fifth accept.
- Stall 3 cycles while (4,2) is presented: if_instr stays 2 and if_pc stays 4 for the 3 stalled cycles plus the release cycle. Next cycle shows (8,3); no skip or repeat.
- redirect_valid with target=12 while (4,2) is presented: next cycle if_valid=0. Following cycle (12,4), then (16,5).
- Redirect to target=10: misalign_err pulses for exactly one cycle and the next valid fetch is (8,3).
- Sequential fetch to PC=124 with MEM_BYTES=128: the fetch at 124 is valid (124+3=127 < 128). The fetch at 128 gives if_valid=0 and fetch_fault=1 (sticky). Redirect to 0 clears fetch_fault.
- Assert rst_n=0 mid-stall: outputs go to reset values before the next edge. After release, fetch resumes at RESET_PC with instr_count=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer for a byte-addressed instruction memory with a
// one-cycle registered read. It aligns fetched words with their PC and handles stall, redirect and range faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] mem_instruction,
  output logic [31:0] mem_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        misalign_err,
  output logic        fetch_fault,
  output logic [31:0] instr_count
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] hold_q, hold_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [31:0] target_aligned;
  logic        pc_in_range;
  logic        target_in_range;

  // Range checks use 33 bits so a PC near the top of the address space cannot wrap into range.
  assign target_aligned  = {redirect_target[31:2], 2'b00};
  assign pc_in_range     = ({1'b0, pc_q} + 33'd3) < 33'(MEM_BYTES);
  assign target_in_range = ({1'b0, target_aligned} + 33'd3) < 33'(MEM_BYTES);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    hold_d     = hold_q;
    misalign_d = 1'b0;
    fault_d    = fault_q;
    count_d    = count_q;

    if (if_valid_q && !stall && !redirect_valid) begin
      count_d = count_q + 32'd1;
    end

    if (redirect_valid) begin
      pc_d       = target_aligned;
      if_valid_d = 1'b0;
      state_d    = RUN;
      misalign_d = |redirect_target[1:0];
      if (target_in_range) begin
        fault_d = 1'b0;
      end
    end else if (stall) begin
      // Capture only on entry: later memory outputs belong to the held PC, not the presented one.
      if (state_q == RUN) begin
        hold_d  = mem_instruction;
        state_d = STALL;
      end
    end else begin
      if_pc_d    = pc_q;
      pc_d       = pc_q + 32'd4;
      state_d    = RUN;
      if_valid_d = pc_in_range;
      if (!pc_in_range) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
      hold_q     <= 32'd0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      hold_q     <= hold_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign mem_pc       = pc_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = (state_q == STALL) ? hold_q : mem_instruction;
  assign if_valid     = if_valid_q;
  assign misalign_err = misalign_q;
  assign fetch_fault  = fault_q;
  assign instr_count  = count_q;

endmodule
